dff_bank_arbiter: RTL and testbench

- Round-robin write arbiter that shares one bank of asynchronously-reset D flip-flop registers among NREQ requesters.
- Grants at most one write per clock and returns a registered ack pulse to the winner.
- Exposes a combinational read port and a saturating write counter.
- Sits between requesting control blocks and the shared flip-flop register bank.

---
 rtl/dff_bank_pkg.sv | 29 ++
 rtl/dff_bank_arbiter_if.sv | 49 ++++
 rtl/dff_bank_arbiter_rr_pick.sv | 36 +++
 rtl/dff_bank_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_pkg
// Description : Shared types, constants and width helpers for the
//               dff_bank_arbiter block (arbiter FSM states, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package dff_bank_pkg;

    // Arbiter FSM states; ST_LOCKED is only reachable when ARB_LOCK_EN is defined
    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int WR_COUNT_W = 16;

    // Index width that never collapses to zero bits for tiny ranges
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (v + 1) mod n for 0 <= v < n
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter_if
// Description : Requester/bank bus of the dff_bank_arbiter. The master side
//               is the set of requesting control blocks, the slave side is
//               the arbiter. The lock vector exists only with ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW  = safe_clog2(DEPTH);
    localparam int IDW = safe_clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*AW-1:0]     wr_addr;
    logic [NREQ*WIDTH-1:0]  wr_data;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [NREQ-1:0]        ack;
    logic                   grant_valid;
    logic [IDW-1:0]         grant_id;
    logic [AW-1:0]          rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic [WR_COUNT_W-1:0]  wr_count;

    modport master (
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output req, wr_addr, wr_data, rd_addr,
        input  ack, grant_valid, grant_id, rd_data, wr_count
    );

    modport slave (
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  req, wr_addr, wr_data, rd_addr,
        output ack, grant_valid, grant_id, rd_data, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first index
//               with req & ~mask, scanning ptr, ptr+1, ... NREQ-1, 0, ...
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [NREQ-1:0] i_mask,
    input  wire logic [IDW-1:0]  i_ptr,
    output logic      [IDW-1:0]  o_winner,
    output logic                 o_valid
);

    int w_idx;

    // Rotating priority scan; the first hit from the pointer wins
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[w_idx] && !i_mask[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IDW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin write arbiter in front of a shared bank of
//               flip-flop registers. One write per clock, registered one-hot
//               ack to the winner, combinational read port and a saturating
//               count of completed writes.
//               Optional owner locking is enabled by defining ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dff_bank_arbiter_if.slave bus
);

    localparam int AW  = safe_clog2(DEPTH);
    localparam int IDW = safe_clog2(NREQ);

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [WR_COUNT_W-1:0]   wr_count_q, wr_count_d;
    logic [WIDTH-1:0]        bank_q [DEPTH];
    logic [WIDTH-1:0]        bank_d [DEPTH];
`ifdef ARB_LOCK_EN
    logic [IDW-1:0]          owner_q, owner_d;
`endif

    logic                    w_locked;
    logic [NREQ-1:0]         w_pick_req;
    logic [NREQ-1:0]         w_pick_mask;
    logic [IDW-1:0]          w_win;
    logic                    w_win_valid;
    logic [AW-1:0]           w_win_addr;
    logic [WIDTH-1:0]        w_win_data;
    logic                    w_win_in_range;
    logic                    w_do_write;

    assign w_locked = (state_q == ST_LOCKED);

    // Picker inputs: a locked owner competes alone and is never ack-masked
    always_comb begin
        w_pick_req  = bus.req;
        w_pick_mask = w_locked ? '0 : ack_q;
`ifdef ARB_LOCK_EN
        if (w_locked) begin
            w_pick_req          = '0;
            w_pick_req[owner_q] = bus.req[owner_q];
        end
`endif
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_mask   (w_pick_mask),
        .i_ptr    (rr_ptr_q),
        .o_winner (w_win),
        .o_valid  (w_win_valid)
    );

    assign w_win_addr     = bus.wr_addr[w_win*AW +: AW];
    assign w_win_data     = bus.wr_data[w_win*WIDTH +: WIDTH];
    assign w_win_in_range = (int'(w_win_addr) < DEPTH);

    // Next-state: FSM, pointer, grant/ack pulse, bank write and counter
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        ack_d         = '0;
        grant_valid_d = 1'b0;
        wr_count_d    = wr_count_q;
        bank_d        = bank_q;
        w_do_write    = 1'b0;
`ifdef ARB_LOCK_EN
        owner_d       = owner_q;
        if (w_locked && !(bus.req[owner_q] && bus.lock[owner_q])) begin
            // Release: no write this edge, resume rotation after the owner
            state_d  = ST_ARB;
            rr_ptr_d = IDW'(wrap_inc(int'(owner_q), NREQ));
        end else if (w_win_valid) begin
            w_do_write = 1'b1;
            if (!w_locked) begin
                if (bus.lock[w_win]) begin
                    state_d = ST_LOCKED;
                    owner_d = w_win;
                end else begin
                    rr_ptr_d = IDW'(wrap_inc(int'(w_win), NREQ));
                end
            end
        end
`else
        if (w_win_valid) begin
            w_do_write = 1'b1;
            rr_ptr_d   = IDW'(wrap_inc(int'(w_win), NREQ));
        end
`endif
        if (w_do_write) begin
            ack_d[w_win]  = 1'b1;
            grant_valid_d = 1'b1;
            grant_id_d    = w_win;
            // Out-of-range index: the grant still completes, the data is dropped
            if (w_win_in_range) begin
                bank_d[w_win_addr] = w_win_data;
                if (wr_count_q != {WR_COUNT_W{1'b1}}) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
            end
        end
    end

    // State registers with immediate clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ARB;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            ack_q         <= '0;
            grant_valid_q <= 1'b0;
            wr_count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
`ifdef ARB_LOCK_EN
            owner_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            ack_q         <= ack_d;
            grant_valid_q <= grant_valid_d;
            wr_count_q    <= wr_count_d;
            bank_q        <= bank_d;
`ifdef ARB_LOCK_EN
            owner_q       <= owner_d;
`endif
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.rd_data     = (int'(bus.rd_addr) < DEPTH) ? bank_q[bus.rd_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8,
//               DEPTH=4). Each driven cycle pushes the expected grant onto a
//               scoreboard queue; it is popped and compared after the edge.
//               Lock scenarios are included when ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       gv;
        logic [1:0] id;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set one requester's address/data lane
    task automatic set_lane(input int i, input logic [1:0] a, input logic [7:0] d);
        bus.wr_addr[i*2 +: 2] = a;
        bus.wr_data[i*8 +: 8] = d;
    endtask

    // Synchronous-looking reset pulse between tests, aligned to negedge
    task automatic pulse_reset();
        bus.req = '0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = 2'(a);
            #1;
            checks++;
            if (bus.rd_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_bank addr=%0d got=%h exp=00", a, bus.rd_data);
            end
        end
        checks++;
        if (bus.ack !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0 || bus.wr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_outs got ack=%b gv=%b id=%0d cnt=%0d exp all 0",
                     bus.ack, bus.grant_valid, bus.grant_id, bus.wr_count);
        end
        // load A5 into register 3, then reset in the middle of the ack cycle
        set_lane(0, 2'd3, 8'hA5);
        bus.req = 4'b0001;
        e = '{gv: 1'b1, id: 2'd0, addr: 2'd3, data: 8'hA5};
        sb.push_back(e);
        @(negedge clk);
        bus.req = '0;
        e = sb.pop_front();
        bus.rd_addr = e.addr;
        #1;
        checks++;
        if (bus.rd_data !== e.data || bus.ack !== 4'b0001 || bus.wr_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_preload got data=%h ack=%b cnt=%0d exp data=%h ack=0001 cnt=1",
                     bus.rd_data, bus.ack, bus.wr_count, e.data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.rd_data !== 8'h00 || bus.ack !== 4'b0 || bus.wr_count !== 16'd0 || bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got data=%h ack=%b cnt=%0d gv=%b exp 00/0000/0/0",
                     bus.rd_data, bus.ack, bus.wr_count, bus.grant_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        exp_t           e;
        logic [NREQ-1:0] exp_ack;
        logic           gv_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_lane(2, 2'd1, 8'h3C);
        for (int c = 0; c < 4; c++) begin
            bus.req = 4'b0100;
            e = '{gv: gv_tab[c], id: 2'd2, addr: 2'd1, data: 8'h3C};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            exp_ack = '0;
            if (e.gv) exp_ack[e.id] = 1'b1;
            checks++;
            if (bus.grant_valid !== e.gv || bus.ack !== exp_ack) begin
                failures++;
                $display("FAIL single_grant cyc=%0d got gv=%b ack=%b exp gv=%b ack=%b",
                         c, bus.grant_valid, bus.ack, e.gv, exp_ack);
            end
        end
        bus.req = '0;
        bus.rd_addr = 2'd1;
        #1;
        checks++;
        if (bus.wr_count !== 16'd2 || bus.rd_data !== 8'h3C) begin
            failures++;
            $display("FAIL single_result got cnt=%0d data=%h exp cnt=2 data=3c", bus.wr_count, bus.rd_data);
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic [NREQ-1:0] exp_ack;
        int   seen [NREQ];
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_lane(i, 2'(i), 8'hC0 | 8'(i));
            seen[i] = 0;
        end
        for (int c = 0; c < 5; c++) begin
            bus.req = (c < 4) ? 4'b1111 : 4'b0000;
            e = '{gv: (c < 4), id: 2'(c), addr: 2'(c), data: 8'hC0 | 8'(c)};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            exp_ack = '0;
            if (e.gv) exp_ack[e.id] = 1'b1;
            for (int i = 0; i < NREQ; i++) if (bus.ack[i] === 1'b1) seen[i]++;
            checks++;
            if (bus.grant_valid !== e.gv || bus.ack !== exp_ack) begin
                failures++;
                $display("FAIL fair_grant cyc=%0d got gv=%b ack=%b exp gv=%b ack=%b",
                         c, bus.grant_valid, bus.ack, e.gv, exp_ack);
            end
            if (e.gv) begin
                bus.rd_addr = e.addr;
                #1;
                checks++;
                if (bus.grant_id !== e.id || bus.rd_data !== e.data) begin
                    failures++;
                    $display("FAIL fair_data cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                             c, bus.grant_id, bus.rd_data, e.id, e.data);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (seen[i] != 1) begin
                failures++;
                $display("FAIL fair_once req=%0d got=%0d acks exp=1", i, seen[i]);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [NREQ-1:0] exp_ack;
        logic [3:0] req_tab [4] = '{4'b1111, 4'b0100, 4'b1001, 4'b1001};
        logic [1:0] id_tab  [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
        for (int c = 0; c < 4; c++) begin
            bus.req = req_tab[c];
            e = '{gv: 1'b1, id: id_tab[c], addr: id_tab[c], data: 8'hC0 | 8'(id_tab[c])};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            exp_ack = '0;
            exp_ack[e.id] = 1'b1;
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.ack !== exp_ack || bus.grant_id !== e.id) begin
                failures++;
                $display("FAIL wrap_grant cyc=%0d got gv=%b ack=%b id=%0d exp gv=1 ack=%b id=%0d",
                         c, bus.grant_valid, bus.ack, bus.grant_id, exp_ack, e.id);
            end
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.ack !== 4'b0 || bus.grant_id !== 2'd0) begin
            failures++;
            $display("FAIL idle_hold got gv=%b ack=%b id=%0d exp gv=0 ack=0000 id=0",
                     bus.grant_valid, bus.ack, bus.grant_id);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [1:0] id_tab [3] = '{2'd0, 2'd1, 2'd0};
        pulse_reset();
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.wr_count_q;
        set_lane(0, 2'd0, 8'h11);
        set_lane(1, 2'd1, 8'h22);
        for (int c = 0; c < 3; c++) begin
            bus.req = 4'b0011;
            e = '{gv: 1'b1, id: id_tab[c], addr: id_tab[c], data: (id_tab[c] == 2'd0) ? 8'h11 : 8'h22};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            bus.rd_addr = e.addr;
            #1;
            checks++;
            if (bus.grant_id !== e.id || bus.rd_data !== e.data || bus.wr_count !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat cyc=%0d got id=%0d data=%h cnt=%h exp id=%0d data=%h cnt=ffff",
                         c, bus.grant_id, bus.rd_data, bus.wr_count, e.id, e.data);
            end
        end
        bus.req = '0;
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        logic [NREQ-1:0] exp_ack;
        logic [3:0] req_tab  [6] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        logic [3:0] lock_tab [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic       gv_tab   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] id_tab   [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        pulse_reset();
        set_lane(0, 2'd0, 8'h0A);
        for (int c = 0; c < 6; c++) begin
            set_lane(1, 2'd2, 8'hD0 | 8'(c));
            bus.req  = req_tab[c];
            bus.lock = lock_tab[c];
            e = '{gv: gv_tab[c], id: id_tab[c], addr: (id_tab[c] == 2'd0) ? 2'd0 : 2'd2,
                  data: (id_tab[c] == 2'd0) ? 8'h0A : (8'hD0 | 8'(c))};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            exp_ack = '0;
            if (e.gv) exp_ack[e.id] = 1'b1;
            checks++;
            if (bus.grant_valid !== e.gv || bus.ack !== exp_ack) begin
                failures++;
                $display("FAIL lock_grant cyc=%0d got gv=%b ack=%b exp gv=%b ack=%b",
                         c, bus.grant_valid, bus.ack, e.gv, exp_ack);
            end
            if (e.gv) begin
                bus.rd_addr = e.addr;
                #1;
                checks++;
                if (bus.rd_data !== e.data) begin
                    failures++;
                    $display("FAIL lock_data cyc=%0d got=%h exp=%h", c, bus.rd_data, e.data);
                end
            end
        end
        bus.req  = '0;
        bus.lock = '0;
    endtask
`endif

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.req     = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
`ifdef ARB_LOCK_EN
        bus.lock    = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_saturation();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
